// File: rtl/shared_port_arbiter.sv
// ============================================================================
// Module      : shared_port_arbiter
// Description : Two-requester round-robin arbiter that owns the select line of
//               a shared 32-bit port mux. Optional grant timeout under the
//               ARB_TIMEOUT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shared_port_arbiter #(
  parameter int unsigned INIT_PRIORITY  = 0,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_0,
  input  logic req_1,
  input  logic done,
  output logic grant_0,
  output logic grant_1,
  output logic selector,
  output logic busy,
  output logic timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_e;

  localparam logic C_INIT = 1'(INIT_PRIORITY);

  if (INIT_PRIORITY > 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("shared_port_arbiter: INIT_PRIORITY must be 0/1 and TIMEOUT_CYCLES >= 1");
  end

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   sel_q, sel_d;
  logic   grant0_q, grant1_q, busy_q;

  logic   w_granted;
  logic   w_owner;
  logic   w_req_own;
  logic   w_req_oth;
  logic   w_expire;
  logic   w_release;
  logic   w_go;
  logic   w_pick;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q;

  // An abort at the expiry cycle means the requester already left: no pulse.
  assign w_expire = w_granted && (cnt_q == C_LIMIT) && !done && w_req_own;
`else
  assign w_expire = 1'b0;
`endif

  assign w_granted = (state_q == ST_GNT0) || (state_q == ST_GNT1);
  assign w_owner   = (state_q == ST_GNT1);
  assign w_req_own = w_owner ? req_1 : req_0;
  assign w_req_oth = w_owner ? req_0 : req_1;
  assign w_release = w_granted && (done || !w_req_own || w_expire);

  always_comb begin
    w_go    = 1'b0;
    w_pick  = sel_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req_0 && req_1) begin
          w_go   = 1'b1;
          w_pick = ~last_q;
        end else if (req_0 || req_1) begin
          w_go   = 1'b1;
          w_pick = req_1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (w_release) begin
          last_d = w_owner;
          if (w_req_oth) begin
            w_go   = 1'b1;
            w_pick = ~w_owner;
          end else if (w_req_own) begin
            w_go   = 1'b1;
            w_pick = w_owner;
          end
        end else begin
          w_go   = 1'b1;
          w_pick = w_owner;
        end
      end
      default: begin
        w_go = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = ST_IDLE;
    sel_d   = sel_q;
    if (w_go) begin
      state_d = w_pick ? ST_GNT1 : ST_GNT0;
      sel_d   = w_pick;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Counter restarts on every grant entry, including back-to-back re-grants.
  always_comb begin
    cnt_d = cnt_q;
    if (w_go && (!w_granted || w_release)) begin
      cnt_d = '0;
    end else if (w_granted && !w_release) begin
      cnt_d = cnt_q + CW'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= ~C_INIT;
      sel_q     <= C_INIT;
      grant0_q  <= 1'b0;
      grant1_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      grant0_q  <= (state_d == ST_GNT0);
      grant1_q  <= (state_d == ST_GNT1);
      busy_q    <= (state_d != ST_IDLE);
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= w_expire;
`endif
    end
  end

  assign grant_0  = grant0_q;
  assign grant_1  = grant1_q;
  assign selector = sel_q;
  assign busy     = busy_q;

`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shared_port_arbiter.sv
// ============================================================================
// Module      : tb_shared_port_arbiter
// Description : Directed self-checking bench for shared_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shared_port_arbiter;

  logic clk;
  logic rst_n;
  logic req_0;
  logic req_1;
  logic done;
  logic grant_0;
  logic grant_1;
  logic selector;
  logic busy;
  logic timeout;

  int checks;
  int errors;

  // Observed vector: {grant_0, grant_1, selector, busy, timeout}
  logic [4:0] obs;
  assign obs = {grant_0, grant_1, selector, busy, timeout};

  localparam logic [4:0] C_IDLE_S0 = 5'b00000;
  localparam logic [4:0] C_IDLE_S1 = 5'b00100;
  localparam logic [4:0] C_G0      = 5'b10010;
  localparam logic [4:0] C_G1      = 5'b01110;
  localparam logic [4:0] C_G1_TO   = 5'b01111;

  shared_port_arbiter #(
    .INIT_PRIORITY  (0),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_0    (req_0),
    .req_1    (req_1),
    .done     (done),
    .grant_0  (grant_0),
    .grant_1  (grant_1),
    .selector (selector),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_0 = 1'b1;
    req_1 = 1'b1;
    done  = 1'b0;
    #12;
    checks++;
    if (obs !== C_IDLE_S0) begin
      errors++;
      $display("FAIL reset_state got %b want %b", obs, C_IDLE_S0);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (obs !== C_G0) begin
      errors++;
      $display("FAIL first_grant got %b want %b", obs, C_G0);
    end
  endtask

  task automatic test_alternate();
    logic [4:0] exp;
    for (int k = 0; k < 9; k++) begin
      exp = (k % 2 == 1) ? C_G1 : C_G0;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL alt_grant_%0d got %b want %b", k, obs, exp);
      end
      if (k == 8) break;
      step();
      step();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL alt_hold_%0d got %b want %b", k, obs, exp);
      end
      done = 1'b1;
      step();
      done = 1'b0;
    end
    req_0 = 1'b0;
    req_1 = 1'b0;
    step();
    checks++;
    if (obs !== C_IDLE_S0) begin
      errors++;
      $display("FAIL alt_idle got %b want %b", obs, C_IDLE_S0);
    end
  endtask

  task automatic test_back_to_back();
    req_1 = 1'b1;
    step();
    checks++;
    if (obs !== C_G1) begin
      errors++;
      $display("FAIL b2b_grant got %b want %b", obs, C_G1);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== C_G1) begin
        errors++;
        $display("FAIL b2b_hold_%0d got %b want %b", i, obs, C_G1);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      checks++;
      if (obs !== C_G1) begin
        errors++;
        $display("FAIL b2b_regrant_%0d got %b want %b", i, obs, C_G1);
      end
    end
    req_1 = 1'b0;
    step();
    checks++;
    if (obs !== C_IDLE_S1) begin
      errors++;
      $display("FAIL b2b_idle_sel got %b want %b", obs, C_IDLE_S1);
    end
  endtask

  task automatic test_done_idle();
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if (obs !== C_IDLE_S1) begin
      errors++;
      $display("FAIL done_idle got %b want %b", obs, C_IDLE_S1);
    end
  endtask

  task automatic test_abort();
    req_0 = 1'b1;
    step();
    req_1 = 1'b1;
    checks++;
    if (obs !== C_G0) begin
      errors++;
      $display("FAIL abort_g0 got %b want %b", obs, C_G0);
    end
    step();
    checks++;
    if (obs !== C_G0) begin
      errors++;
      $display("FAIL abort_hold got %b want %b", obs, C_G0);
    end
    req_0 = 1'b0;
    step();
    checks++;
    if (obs !== C_G1) begin
      errors++;
      $display("FAIL abort_handoff got %b want %b", obs, C_G1);
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== C_IDLE_S0) begin
      errors++;
      $display("FAIL async_reset got %b want %b", obs, C_IDLE_S0);
    end
    req_1 = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    checks++;
    if (obs !== C_IDLE_S0) begin
      errors++;
      $display("FAIL post_reset_idle got %b want %b", obs, C_IDLE_S0);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    req_0 = 1'b1;
    step();
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (obs !== C_G0) begin
        errors++;
        $display("FAIL to_hold_%0d got %b want %b", c, obs, C_G0);
      end
      if (c == 2) req_1 = 1'b1;
      if (c < 4) step();
    end
    step();
    checks++;
    if (obs !== C_G1_TO) begin
      errors++;
      $display("FAIL to_release got %b want %b", obs, C_G1_TO);
    end
    step();
    checks++;
    if (obs !== C_G1) begin
      errors++;
      $display("FAIL to_pulse_end got %b want %b", obs, C_G1);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    step();
    step();
    checks++;
    if (obs !== C_G0) begin
      errors++;
      $display("FAIL to_regrant got %b want %b", obs, C_G0);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if (obs !== C_G1) begin
      errors++;
      $display("FAIL to_done_wins got %b want %b", obs, C_G1);
    end
    req_0 = 1'b0;
    req_1 = 1'b0;
    step();
    checks++;
    if (obs !== C_IDLE_S1) begin
      errors++;
      $display("FAIL to_idle got %b want %b", obs, C_IDLE_S1);
    end
  endtask
`else
  task automatic test_timeout();
    req_0 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (obs !== C_G0) begin
        errors++;
        $display("FAIL no_to_hold_%0d got %b want %b", c, obs, C_G0);
      end
    end
    req_0 = 1'b0;
    step();
    checks++;
    if (obs !== C_IDLE_S0) begin
      errors++;
      $display("FAIL no_to_idle got %b want %b", obs, C_IDLE_S0);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alternate();
    test_back_to_back();
    test_done_idle();
    test_abort();
    test_async_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
